// File: rtl/ysyx_24120013_pkg.sv
// Shared definitions for the instruction fetch unit.
//   ADDR_WIDTH_DEF / DATA_WIDTH_DEF : default PC and instruction widths
//   RESET_PC_DEF                    : default first fetch address
//   fetch_state_t                   : fetch control state {RUN, HALT}
//   fetch_entry_t                   : instruction buffer entry at default widths
package ysyx_24120013_pkg;

   localparam int unsigned ADDR_WIDTH_DEF = 32;
   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam logic [31:0] RESET_PC_DEF   = 32'h8000_0000;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [DATA_WIDTH_DEF-1:0] inst;
      logic [ADDR_WIDTH_DEF-1:0] pc;
      logic                      fault;
   } fetch_entry_t;

endpackage

// File: rtl/ysyx_24120013_ifu_fifo.sv
// Synchronous FIFO with flush, used as the instruction buffer and as the
// in-flight PC queue of the fetch unit.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : drop all entries (wins over push/pop)
//   push/data  : write one entry (ignored when full)
//   pop        : remove head entry (ignored when empty)
//   head_data  : current head entry (undefined when empty)
//   count      : number of valid entries
//   full/empty : occupancy flags
module ysyx_24120013_ifu_fifo #(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign head_data = mem[rd_ptr_q];
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage needs no reset: entries are only observed while counted valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/ysyx_24120013_ifu_fetch.sv
// Instruction fetch stage.
// Owns the fetch PC, issues word reads to instruction memory under a credit
// limit of DEPTH (in flight plus buffered), buffers responses and hands them
// to decode. Redirects flush stale work; memory errors halt fetch until the
// next redirect.
//   clk, rst             : clock, asynchronous active-high reset
//   mem_req_*            : valid/ready request channel (word address)
//   mem_rsp_*            : in-order valid-only response channel
//   redirect_valid/_pc   : one-cycle redirect pulse and new target
//   out_valid/out_ready  : decode handshake
//   out_inst/pc/fault    : head of the instruction buffer
module ysyx_24120013_ifu_fetch
   import ysyx_24120013_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned           DATA_WIDTH = DATA_WIDTH_DEF,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF),
   parameter int unsigned           DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] mem_rsp_data,
   input  logic                  mem_rsp_err,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_inst,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic                  out_fault
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   // Outstanding/drop counters need headroom beyond DEPTH: back-to-back
   // redirects can leave several generations of dropped responses pending.
   localparam int unsigned OW = CW + 3;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] inst;
      logic [ADDR_WIDTH-1:0] pc;
      logic                  fault;
   } entry_t;

   fetch_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] fetch_pc_q;
   logic [OW-1:0]         outstanding_q;
   logic [OW-1:0]         drop_cnt_q;
   logic [OW-1:0]         outstanding_nxt;
   logic [OW-1:0]         live;
   logic [OW-1:0]         credit_used;

   logic                  req_fire;
   logic                  rsp_drop;
   logic                  rsp_take;
   logic                  out_fire;

   entry_t                buf_push_entry;
   entry_t                buf_head;
   logic [CW-1:0]         buf_count;
   logic                  buf_full;
   logic                  buf_empty;

   logic [ADDR_WIDTH-1:0] if_head_pc;
   logic [CW-1:0]         if_count;
   logic                  if_full;
   logic                  if_empty;

   // Credit: responses still owed to us (excluding ones to be dropped) plus
   // buffered entries must stay below DEPTH, so no response meets a full buffer.
   assign live          = outstanding_q - drop_cnt_q;
   assign credit_used   = live + OW'(buf_count);
   assign mem_req_valid = !rst && (state_q == RUN) && !redirect_valid &&
                          (credit_used < OW'(DEPTH));
   assign mem_req_addr  = {fetch_pc_q[ADDR_WIDTH-1:2], 2'b00};
   assign req_fire      = mem_req_valid && mem_req_ready;

   assign rsp_drop        = mem_rsp_valid && (redirect_valid || (drop_cnt_q != '0));
   assign rsp_take        = mem_rsp_valid && !rsp_drop;
   assign outstanding_nxt = outstanding_q + OW'(req_fire) - OW'(mem_rsp_valid);

   assign out_fire  = out_valid && out_ready;
   assign out_valid = !buf_empty;
   assign out_inst  = buf_empty ? '0 : buf_head.inst;
   assign out_pc    = buf_empty ? '0 : buf_head.pc;
   assign out_fault = buf_empty ? 1'b0 : buf_head.fault;

   always_comb begin
      buf_push_entry.inst  = mem_rsp_err ? '0 : mem_rsp_data;
      buf_push_entry.pc    = if_head_pc;
      buf_push_entry.fault = mem_rsp_err;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         outstanding_q <= outstanding_nxt;
         if (redirect_valid) begin
            fetch_pc_q <= redirect_pc;
            drop_cnt_q <= outstanding_nxt;
         end else begin
            if (req_fire) fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(4);
            if (mem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_q <= drop_cnt_q - OW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (redirect_valid)                state_d = RUN;
      else if (rsp_take && mem_rsp_err)  state_d = HALT;
   end

   ysyx_24120013_ifu_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_inst_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (rsp_take),
      .push_data (buf_push_entry),
      .pop       (out_fire),
      .head_data (buf_head),
      .count     (buf_count),
      .full      (buf_full),
      .empty     (buf_empty)
   );

   // Holds PCs only for responses that will be kept; the redirect flush plus
   // drop_cnt account for responses already owed to the old stream.
   ysyx_24120013_ifu_fifo #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (DEPTH)
   ) u_inflight_pc (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (req_fire),
      .push_data (fetch_pc_q),
      .pop       (rsp_take),
      .head_data (if_head_pc),
      .count     (if_count),
      .full      (if_full),
      .empty     (if_empty)
   );

   a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
      mem_rsp_valid |-> (outstanding_q != '0));
   a_buf_room: assert property (@(posedge clk) disable iff (rst)
      rsp_take |-> !buf_full);
   a_inflight_room: assert property (@(posedge clk) disable iff (rst)
      req_fire |-> !if_full);
   a_inflight_pc: assert property (@(posedge clk) disable iff (rst)
      rsp_take |-> !if_empty);
   a_live_count: assert property (@(posedge clk) disable iff (rst)
      OW'(if_count) == live);

endmodule
